// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU/accumulator.
// Op encodings, op width and the result flag bundle.
package alu_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_CMP  = 3'd5,
        OP_ACC  = 3'd6,
        OP_CLRA = 3'd7
    } op_e;

    typedef struct packed {
        logic parity;
        logic overflow;
        logic carry;
        logic greater;
        logic less;
        logic is_eq;
    } flags_t;

endpackage

// File: rtl/alu_pipe_acc_flags_calc.sv
// Combinational result/flag builder between S1 and S2.
// Clamps on signed overflow when ALU_SAT_EN is defined.
module alu_flags_calc
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit CMP_SIGNED = 1'b0
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH:0]   sum,
    output logic [WIDTH-1:0] y,
    output flags_t           flags
);

    localparam int MSB = WIDTH - 1;

    logic ov;
    logic cy;
    logic gt;
    logic lt;

    always_comb begin
        y  = '0;
        ov = 1'b0;
        cy = 1'b0;
        unique case (op)
            OP_ADD: begin
                y  = sum[MSB:0];
                cy = sum[WIDTH];
                ov = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                y  = sum[MSB:0];
                cy = sum[WIDTH];
                ov = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_CMP:  y = a;
            OP_ACC: begin
                y  = sum[MSB:0];
                cy = sum[WIDTH];
                ov = (acc[MSB] == a[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_CLRA: y = acc;
        endcase
`ifdef ALU_SAT_EN
        // On overflow both addends share a's sign, so it picks the rail.
        if (ov) begin
            y = a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                       : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        if (CMP_SIGNED) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
    end

    always_comb begin
        flags.parity   = ^y;
        flags.overflow = ov;
        flags.carry    = cy;
        flags.greater  = gt;
        flags.less     = lt;
        flags.is_eq    = (a == b);
    end

endmodule

// File: rtl/alu_pipe_acc.sv
// Two-stage pipelined ALU with accumulator and valid/ready on both sides.
// Build option: ALU_SAT_EN enables signed saturation of ADD/SUB/ACC.
module alu_pipe_acc
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit CMP_SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_e              in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_parity,
    output logic             out_overflow,
    output logic             out_carry,
    output logic             out_greater,
    output logic             out_less,
    output logic             out_is_eq,
    output logic [WIDTH-1:0] acc_value
);

    logic             live;
    logic             s1_valid;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s2_valid;
    logic [WIDTH-1:0] s2_y;
    flags_t           s2_flags;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] y_n;
    flags_t           flags_n;
    logic             s2_free;
    logic             advance;

    assign s2_free  = !s2_valid || out_ready;
    // live holds ready low until the first edge after reset release.
    assign in_ready = live && (!s1_valid || s2_free);
    assign advance  = s1_valid && s2_free;

    always_comb begin
        unique case (s1_op)
            OP_SUB:  sum = {1'b0, s1_a} - {1'b0, s1_b};
            OP_ACC:  sum = {1'b0, acc_q} + {1'b0, s1_a};
            OP_CLRA: sum = {1'b0, acc_q};
            default: sum = {1'b0, s1_a} + {1'b0, s1_b};
        endcase
    end

    alu_flags_calc #(
        .WIDTH      (WIDTH),
        .CMP_SIGNED (CMP_SIGNED)
    ) u_calc (
        .op    (s1_op),
        .a     (s1_a),
        .b     (s1_b),
        .acc   (acc_q),
        .sum   (sum),
        .y     (y_n),
        .flags (flags_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live     <= 1'b0;
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_valid <= 1'b0;
            s2_y     <= '0;
            s2_flags <= '0;
            acc_q    <= '0;
        end else begin
            live <= 1'b1;
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_op <= in_op;
                    s1_a  <= in_a;
                    s1_b  <= in_b;
                end
            end
            if (s2_free) begin
                s2_valid <= s1_valid;
            end
            if (advance) begin
                s2_y     <= y_n;
                s2_flags <= flags_n;
                if (s1_op == OP_ACC) begin
                    acc_q <= y_n;
                end else if (s1_op == OP_CLRA) begin
                    acc_q <= '0;
                end
            end
        end
    end

    assign out_valid    = s2_valid;
    assign out_y        = s2_y;
    assign out_parity   = s2_flags.parity;
    assign out_overflow = s2_flags.overflow;
    assign out_carry    = s2_flags.carry;
    assign out_greater  = s2_flags.greater;
    assign out_less     = s2_flags.less;
    assign out_is_eq    = s2_flags.is_eq;
    assign acc_value    = acc_q;

endmodule

// File: tb/tb_alu_pipe_acc.sv
// Directed bench for alu_pipe_acc (WIDTH=8, unsigned compare).
// Honours ALU_SAT_EN for the saturating expectations.
module tb_alu_pipe_acc;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    op_e        in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_y;
    logic       out_parity;
    logic       out_overflow;
    logic       out_carry;
    logic       out_greater;
    logic       out_less;
    logic       out_is_eq;
    logic [7:0] acc_value;

    alu_pipe_acc #(.WIDTH(8), .CMP_SIGNED(1'b0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_y        (out_y),
        .out_parity   (out_parity),
        .out_overflow (out_overflow),
        .out_carry    (out_carry),
        .out_greater  (out_greater),
        .out_less     (out_less),
        .out_is_eq    (out_is_eq),
        .acc_value    (acc_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] y;
        logic [5:0] f;
        bit         lat;
    } exp_t;

    exp_t       exp_q[$];
    int         acc_cyc_q[$];
    int         n_tot = 0;
    int         n_bad = 0;
    int         n_acc = 0;
    int         n_out = 0;
    int         cyc = 0;
    logic [7:0] m_acc = 8'h00;
    logic [5:0] obs_f;

    assign obs_f = {out_parity, out_overflow, out_carry,
                    out_greater, out_less, out_is_eq};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_tot++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        int   t;
        if (rst_n) begin
            if (in_valid && in_ready) begin
                acc_cyc_q.push_back(cyc);
                n_acc++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("extra", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    t = (acc_cyc_q.size() != 0) ? acc_cyc_q.pop_front() : -99;
                    chk("y", out_y, e.y);
                    chk("flg", obs_f, e.f);
                    if (e.lat) chk("lat", cyc - t, 2);
                end
            end
        end
    end

    task automatic push(input logic [7:0] y, input logic [5:0] f);
        exp_t e;
        e.y = y;
        e.f = f;
        e.lat = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic mpush(input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input bit lat);
        exp_t       e;
        logic [8:0] s;
        logic [7:0] y;
        logic       ov;
        logic       c;
        s = 9'h0;
        ov = 1'b0;
        c = 1'b0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                ov = (a[7] == b[7]) && (s[7] != a[7]);
            end
            3'd1: begin
                s = {1'b0, a} - {1'b0, b};
                ov = (a[7] != b[7]) && (s[7] != a[7]);
            end
            3'd2: s = {1'b0, a & b};
            3'd3: s = {1'b0, a | b};
            3'd4: s = {1'b0, a ^ b};
            3'd5: s = {1'b0, a};
            3'd6: begin
                s = {1'b0, m_acc} + {1'b0, a};
                ov = (m_acc[7] == a[7]) && (s[7] != a[7]);
            end
            default: s = {1'b0, m_acc};
        endcase
        if (op == 3'd0 || op == 3'd1 || op == 3'd6) c = s[8];
        y = s[7:0];
`ifdef ALU_SAT_EN
        if (ov) y = a[7] ? 8'h80 : 8'h7F;
`endif
        if (op == 3'd6) m_acc = y;
        if (op == 3'd7) m_acc = 8'h00;
        e.y = y;
        e.f = {^y, ov, c, a > b, a < b, a == b};
        e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        in_op = op_e'(op);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk("accept_to", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        int n0;
        int o0;
        int k;
        logic [2:0] rop;
        logic [7:0] ra;
        logic [7:0] rb;
        in_op = OP_ADD;
        in_a = 8'h00;
        in_b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", out_valid, 0);
        chk("rst_rdy", in_ready, 0);
        chk("rst_acc", acc_value, 0);
        chk("rst_y", out_y, 0);
        chk("rst_flg", obs_f, 0);

        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy", in_ready, 1);

`ifdef ALU_SAT_EN
        push(8'h7F, 6'b110100);
`else
        push(8'h80, 6'b110100);
`endif
        send(3'd0, 8'h7F, 8'h01);
        push(8'h00, 6'b000001);
        send(3'd1, 8'h05, 8'h05);
        push(8'hFE, 6'b101010);
        send(3'd1, 8'h03, 8'h05);
        push(8'h00, 6'b000001);
        send(3'd7, 8'h00, 8'h00);
        push(8'h10, 6'b100100);
        send(3'd6, 8'h10, 8'h00);
        push(8'h30, 6'b000100);
        send(3'd6, 8'h20, 8'h00);
        push(8'h20, 6'b101100);
        send(3'd6, 8'hF0, 8'h00);
        wait_drain();
        chk("acc20", acc_value, 8'h20);

        out_ready = 1'b0;
        push(8'h03, 6'b000010);
        push(8'h30, 6'b000010);
`ifdef ALU_SAT_EN
        push(8'h80, 6'b111001);
`else
        push(8'h00, 6'b011001);
`endif
        push(8'h00, 6'b001100);
        n0 = n_acc;
        o0 = n_out;
        fork
            begin
                send(3'd0, 8'h01, 8'h02);
                send(3'd0, 8'h10, 8'h20);
                send(3'd0, 8'h80, 8'h80);
                send(3'd0, 8'hFF, 8'h01);
            end
            begin
                repeat (6) @(posedge clk);
                #2;
                chk("bp_acc", n_acc - n0, 2);
                chk("bp_rdy", in_ready, 0);
                chk("bp_vld", out_valid, 1);
                chk("bp_frz", out_y, 8'h03);
                out_ready = 1'b1;
                k = 0;
                while ((n_out - o0) < 4 && k < 20) begin
                    @(posedge clk);
                    #2;
                    k++;
                end
                chk("bp_rate", k, 4);
            end
        join
        wait_drain();

        push(8'h20, 6'b100001);
        send(3'd7, 8'h00, 8'h00);
        m_acc = 8'h00;
        for (int i = 0; i < 16; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            rb = 8'($urandom);
            mpush(rop, ra, rb, 1'b1);
            send(rop, ra, rb);
        end
        wait_drain();

        mpush(3'd7, 8'h00, 8'h00, 1'b0);
        send(3'd7, 8'h00, 8'h00);
        wait_drain();
        out_ready = 1'b0;
        mpush(3'd6, 8'h55, 8'h00, 1'b0);
        send(3'd6, 8'h55, 8'h00);
        mpush(3'd0, 8'h01, 8'h01, 1'b0);
        send(3'd0, 8'h01, 8'h01);
        chk("pre_acc", acc_value, 8'h55);
        chk("pre_vld", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_vld", out_valid, 0);
        chk("mr_y", out_y, 0);
        chk("mr_flg", obs_f, 0);
        chk("mr_acc", acc_value, 0);
        chk("mr_rdy", in_ready, 0);
        exp_q.delete();
        acc_cyc_q.delete();
        o0 = n_out;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("stale_vld", out_valid, 0);
        chk("stale_n", n_out - o0, 0);
        push(8'h05, 6'b000010);
        send(3'd0, 8'h02, 8'h03);
        wait_drain();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
